trng_markov: RTL and testbench

Entropy-conditioning stage of the true random number generator. Samples six raw entropy lanes, each with its own per-lane valid strobe, and debiases each lane with a von Neumann extractor. Queues the surviving bits in a small bit FIFO and streams them out serially, one bit per clock. Sits between the ring-oscillator sampler array and the random-bit consumer.

---
 rtl/trng_pkg.sv | 14 +
 rtl/trng_bit_fifo.sv | 66 ++++++
 rtl/trng_markov.sv | 83 ++++++++
 tb/tb_trng_markov.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared constants and lane-state type for the TRNG entropy conditioner.
package trng_pkg;
  localparam int N_SRC      = 6;
  localparam int FIFO_DEPTH = 16;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int PCNT_W     = $clog2(N_SRC + 1);

  // Von Neumann pairing state of one lane.
  typedef struct packed {
    logic hold;
    logic data;
  } lane_t;
endpackage

// File: rtl/trng_bit_fifo.sv
// Multi-push, single-pop bit FIFO; excess pushes are dropped from the top and latch overflow.
module trng_bit_fifo
  import trng_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PCNT_W-1:0] push_cnt_i,
  input  logic [N_SRC-1:0]  push_data_i,
  output logic              out_valid_o,
  output logic              out_bit_o,
  output logic              writing_o,
  output logic              overflow_o
);

  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  writing_q, writing_d;
  logic                  overflow_q, overflow_d;
  logic                  pop;
  logic [CNT_W-1:0]      cnt_post, free, push_ext, accept;

  always_comb begin
    pop      = (count_q != '0);
    cnt_post = count_q - CNT_W'(pop);
    // Room is measured after this edge's pop so a full FIFO still takes one bit.
    free     = CNT_W'(FIFO_DEPTH) - cnt_post;
    push_ext = CNT_W'(push_cnt_i);
    accept   = (push_ext > free) ? free : push_ext;
    mem_d    = mem_q;
    for (int k = 0; k < N_SRC; k++) begin
      if (CNT_W'(k) < accept) begin
        mem_d[wr_ptr_q + PTR_W'(k)] = push_data_i[k];
      end
    end
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + accept[PTR_W-1:0];
    count_d    = cnt_post + accept;
    writing_d  = (accept != '0);
    overflow_d = overflow_q | (push_ext > free);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      writing_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      writing_q  <= writing_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid_o = (count_q != '0);
  assign out_bit_o   = (count_q != '0) ? mem_q[rd_ptr_q] : 1'b0;
  assign writing_o   = writing_q;
  assign overflow_o  = overflow_q;

endmodule

// File: rtl/trng_markov.sv
// Six-lane von Neumann debiaser feeding a serial bit FIFO.
// Optional raw bypass input is enabled with `define TRNG_BYPASS_EN.
module trng_markov
  import trng_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
`ifdef TRNG_BYPASS_EN
  input  logic             bypass,
`endif
  input  logic [N_SRC-1:0] bits,
  input  logic [N_SRC-1:0] valid,
  output logic             out_valid,
  output logic             out,
  output logic             writing,
  output logic             overflow
);

  // Output stream is pop-only: there is no ready; whenever out_valid is high
  // the consumer takes out and the head is removed on the next rising edge.

  lane_t [N_SRC-1:0] lane_q, lane_d;
  logic [N_SRC-1:0]  emit_vld, emit_bit;
  logic [N_SRC-1:0]  push_data;
  logic [PCNT_W-1:0] push_cnt;

  always_comb begin
    lane_d   = lane_q;
    emit_vld = '0;
    emit_bit = '0;
    for (int i = 0; i < N_SRC; i++) begin
`ifdef TRNG_BYPASS_EN
      if (bypass) begin
        lane_d[i].hold = 1'b0;
        emit_vld[i]    = valid[i];
        emit_bit[i]    = bits[i];
      end else
`endif
      if (valid[i]) begin
        if (!lane_q[i].hold) begin
          lane_d[i].hold = 1'b1;
          lane_d[i].data = bits[i];
        end else begin
          lane_d[i].hold = 1'b0;
          emit_vld[i]    = (lane_q[i].data != bits[i]);
          emit_bit[i]    = lane_q[i].data;
        end
      end
    end
  end

  // Pack emitted bits to the bottom, lane 0 first, so the FIFO sees a dense burst.
  always_comb begin
    push_data = '0;
    push_cnt  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (emit_vld[i]) begin
        push_data[push_cnt] = emit_bit[i];
        push_cnt            = push_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  trng_bit_fifo u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_cnt_i  (push_cnt),
    .push_data_i (push_data),
    .out_valid_o (out_valid),
    .out_bit_o   (out),
    .writing_o   (writing),
    .overflow_o  (overflow)
  );

endmodule

// File: tb/tb_trng_markov.sv
// Directed bench for trng_markov with a queue-level reference model checked every cycle.
module tb_trng_markov;

  logic       clk;
  logic       reset;
  logic [5:0] bits;
  logic [5:0] valid;
  logic       out_valid;
  logic       out;
  logic       writing;
  logic       overflow;
`ifdef TRNG_BYPASS_EN
  logic       bypass;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [0:0] exp_q[$];
  bit         m_hold[6];
  bit         m_held[6];
  bit         m_writing;
  bit         m_overflow;

  trng_markov dut (
    .clk       (clk),
    .reset     (reset),
`ifdef TRNG_BYPASS_EN
    .bypass    (bypass),
`endif
    .bits      (bits),
    .valid     (valid),
    .out_valid (out_valid),
    .out       (out),
    .writing   (writing),
    .overflow  (overflow)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      m_hold[i] = 1'b0;
      m_held[i] = 1'b0;
    end
    m_writing  = 1'b0;
    m_overflow = 1'b0;
  endtask

  // One clock edge of the behaviour: consume head, pair samples, enqueue survivors.
  task automatic model_step(input logic [5:0] b, input logic [5:0] v);
    bit pushed;
    pushed = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      if (v[i]) begin
        if (!m_hold[i]) begin
          m_hold[i] = 1'b1;
          m_held[i] = b[i];
        end else begin
          m_hold[i] = 1'b0;
          if (m_held[i] != b[i]) begin
            if (exp_q.size() < 16) begin
              exp_q.push_back(m_held[i]);
              pushed = 1'b1;
            end else begin
              m_overflow = 1'b1;
            end
          end
        end
      end
    end
    m_writing = pushed;
  endtask

  // Driver: apply a vector for one edge, advance the model, land 1 time unit after the edge.
  task automatic drive(input logic [5:0] b, input logic [5:0] v);
    bits  = b;
    valid = v;
    @(posedge clk);
    model_step(b, v);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(6'b000000, 6'b000000);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_clear();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_writing", writing, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // Scoreboard compare on the falling edge
  always @(negedge clk) begin
    check("out_valid", out_valid, logic'(exp_q.size() != 0));
    check("out", out, (exp_q.size() != 0) ? exp_q[0] : 1'b0);
    check("writing", writing, m_writing);
    check("overflow", overflow, m_overflow);
  end

  logic [5:0] mix_exp;

  initial begin
    reset = 1'b0;
    bits  = '0;
    valid = '0;
`ifdef TRNG_BYPASS_EN
    bypass = 1'b0;
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("init_out_valid", out_valid, 1'b0);
    check("init_out", out, 1'b0);
    check("init_writing", writing, 1'b0);
    check("init_overflow", overflow, 1'b0);
    #1 reset = 1'b1;
    idle(2);

    // Lanes 1 and 2 emit 1,1; lane 0 discards 1,1; lane 5 stores
    drive(6'b111111, 6'b011111);
    drive(6'b010001, 6'b100111);
    check("pair_writing", writing, 1'b1);
    check("pair_out_a", out, 1'b1);
    drive(6'b000000, 6'b000000);
    check("pair_valid_b", out_valid, 1'b1);
    check("pair_out_b", out, 1'b1);
    drive(6'b000000, 6'b000000);
    check("pair_drained", out_valid, 1'b0);

    // Lanes 4,5 discard equal pairs, lanes 0..2 store
    drive(6'b010101, 6'b110111);
    check("discard_writing", writing, 1'b0);
    check("discard_valid", out_valid, 1'b0);

    pulse_reset();

    // Lane 0: 0 then 1 emits a single 0
    drive(6'b000000, 6'b000001);
    check("l0_first_writing", writing, 1'b0);
    drive(6'b000001, 6'b000001);
    check("l0_valid", out_valid, 1'b1);
    check("l0_out", out, 1'b0);
    drive(6'b000000, 6'b000000);
    check("l0_single", out_valid, 1'b0);

    // All lanes differ: output order is lane 0..5 of the first sample
    drive(6'b110010, 6'b111111);
    drive(6'b001101, 6'b111111);
    mix_exp = 6'b110010;
    for (int i = 0; i < 6; i++) begin
      check("mix_order", out, mix_exp[i]);
      drive(6'b000000, 6'b000000);
    end
    check("mix_drained", out_valid, 1'b0);

    // Six-lane bursts every second cycle overrun the FIFO
    for (int p = 0; p < 5; p++) begin
      drive(6'b101010, 6'b111111);
      drive(6'b010101, 6'b111111);
      if (p == 2) check("ovf_not_yet", overflow, 1'b0);
      if (p == 3) check("ovf_set", overflow, 1'b1);
    end
    check("ovf_full_valid", out_valid, 1'b1);
    idle(20);
    check("ovf_drained", out_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);

    // Reset while the FIFO holds bits
    drive(6'b111111, 6'b111111);
    drive(6'b000000, 6'b111111);
    check("pre_reset_valid", out_valid, 1'b1);
    pulse_reset();
    drive(6'b000001, 6'b000001);
    check("post_reset_writing", writing, 1'b0);
    check("post_reset_valid", out_valid, 1'b0);
    drive(6'b000000, 6'b000001);
    check("post_reset_emit", out, 1'b1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
